// File: rtl/fb_pkg.sv
`default_nettype none
// Shared pattern codes, colour constants and fill FSM encoding for the frame-buffer pattern writer.
package fb_pkg;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_VBAR  = 2'd1;
    localparam logic [1:0] PAT_HBAR  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    // RGB111 colours, bit order {R, G, B}
    localparam logic [2:0] RED_VGA   = 3'b100;
    localparam logic [2:0] GREEN_VGA = 3'b010;
    localparam logic [2:0] BLUE_VGA  = 3'b001;
    localparam logic [2:0] WHITE_VGA = 3'b111;
    localparam logic [2:0] BLACK_VGA = 3'b000;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        FILL = 2'd1,
        IDLE = 2'd2
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_pattern_writer_btn_debounce.sv
`default_nettype none
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 750000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level held long enough: accept it; only a rising edge is a press.
                stable <= sync2;
                cnt    <= '0;
                press  <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_pattern_writer.sv
`default_nettype none
// Frame-buffer write-side producer: fills an IMG_W x IMG_H RGB111 image with one
// of four test patterns, one pixel per clock, refilling after reset and on each pattern change.
module fb_pattern_writer
    import fb_pkg::*;
#(
    parameter int AW              = 8,
    parameter int DW              = 3,
    parameter int IMG_W           = 16,
    parameter int IMG_H           = 16,
    parameter int DEBOUNCE_CYCLES = 750000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bntr,
    input  logic          bntl,
    output logic [AW-1:0] addr_out,
    output logic [DW-1:0] data_out,
    output logic          regwrite,
    output logic          busy,
    output logic [1:0]    pattern_sel
);

    // Patterns read x[2:0] / y[2:0], so both dimensions are expected to be at least 8.
    localparam int            XW     = $clog2(IMG_W);
    localparam int            YW     = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    fill_state_t   state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic          press_r;
    logic          press_l;
    logic          change;
    logic [1:0]    next_sel;

    logic          do_write;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic [1:0]    wsel;
    logic [2:0]    pixel;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_r (
        .clk   (clk),
        .rst   (rst),
        .btn   (bntr),
        .press (press_r)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_l (
        .clk   (clk),
        .rst   (rst),
        .btn   (bntl),
        .press (press_l)
    );

    function automatic logic [2:0] pattern_pixel(input logic [1:0] pat,
                                                 input logic [2:0] px,
                                                 input logic [2:0] py);
        case (pat)
            PAT_SOLID: pattern_pixel = RED_VGA;
            PAT_VBAR:  pattern_pixel = px;
            PAT_HBAR:  pattern_pixel = py;
            default:   pattern_pixel = (px[2] ^ py[2]) ? WHITE_VGA : BLACK_VGA;
        endcase
    endfunction

    // Simultaneous left and right presses cancel out.
    assign change   = press_r ^ press_l;
    assign next_sel = press_r ? pattern_sel + 2'd1 : pattern_sel - 2'd1;

    // A pattern change writes pixel (0,0) of the new pattern in the same cycle it
    // is accepted, so a restarted fill has no gap cycle.
    always_comb begin
        do_write = 1'b0;
        wx       = x;
        wy       = y;
        wsel     = pattern_sel;
        if (state != INIT && change) begin
            do_write = 1'b1;
            wx       = '0;
            wy       = '0;
            wsel     = next_sel;
        end else if (state == FILL) begin
            do_write = 1'b1;
        end
    end

    assign pixel = pattern_pixel(wsel, wx[2:0], wy[2:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            x           <= '0;
            y           <= '0;
            addr_out    <= '0;
            data_out    <= '0;
            regwrite    <= 1'b0;
            busy        <= 1'b0;
            pattern_sel <= PAT_SOLID;
        end else if (do_write) begin
            regwrite    <= 1'b1;
            busy        <= 1'b1;
            addr_out    <= AW'({wy, wx});
            data_out    <= DW'(pixel);
            pattern_sel <= wsel;
            if (wx == X_LAST) begin
                x <= '0;
                y <= wy + YW'(1);
                if (wy == Y_LAST) begin
                    state <= IDLE;
                end else begin
                    state <= FILL;
                end
            end else begin
                x     <= wx + XW'(1);
                y     <= wy;
                state <= FILL;
            end
        end else begin
            // Address and data hold their last values while idle.
            regwrite <= 1'b0;
            busy     <= 1'b0;
            if (state == INIT) begin
                state <= FILL;
                x     <= '0;
                y     <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_pattern_writer.sv
`default_nettype none
// Scoreboard bench for fb_pattern_writer: stimulus schedules expected frame writes
// on a cycle timeline, a monitor checks every cycle of DUT output against it.
module tb_fb_pattern_writer;

    localparam int AW        = 8;
    localparam int DW        = 3;
    localparam int IMG_W     = 16;
    localparam int IMG_H     = 16;
    localparam int DEB       = 4;
    localparam int NPIX      = IMG_W * IMG_H;
    // Two synchronizer flops, DEB stable cycles, then the cycle the pulse is acted on.
    localparam int PRESS_LAT = 2 + DEB + 1;

    logic          clk;
    logic          rst;
    logic          bntr;
    logic          bntl;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out;
    logic          regwrite;
    logic          busy;
    logic [1:0]    pattern_sel;

    typedef struct {
        int c;
        int addr;
        int data;
        int pat;
    } wr_t;

    wr_t      exp_q[$];
    int       cyc       = 0;
    int       n_cmp     = 0;
    int       n_fail    = 0;
    int       last_addr = 0;
    int       last_data = 0;
    int       last_pat  = 0;
    int       model_sel = 0;
    int       cur_start = 0;
    logic [2:0] frame [NPIX];

    fb_pattern_writer #(
        .AW              (AW),
        .DW              (DW),
        .IMG_W           (IMG_W),
        .IMG_H           (IMG_H),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bntr        (bntr),
        .bntl        (bntl),
        .addr_out    (addr_out),
        .data_out    (data_out),
        .regwrite    (regwrite),
        .busy        (busy),
        .pattern_sel (pattern_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int ref_pixel(int p, int a);
        int px;
        int py;
        px = a % IMG_W;
        py = a / IMG_W;
        case (p)
            0:       return 4;
            1:       return px % 8;
            2:       return py % 8;
            default: return (((px / 4) % 2) != ((py / 4) % 2)) ? 7 : 0;
        endcase
    endfunction

    function automatic void push_fill(int s, int p);
        wr_t e;
        for (int a = 0; a < NPIX; a++) begin
            e.c    = s + a;
            e.addr = a;
            e.data = ref_pixel(p, a);
            e.pat  = p;
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: every cycle either a scheduled write or an idle hold is expected.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (regwrite) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("write_cycle", cyc, e.c);
                check("write_addr", int'(addr_out), e.addr);
                check("write_data", int'(data_out), e.data);
                check("fill_sel", int'(pattern_sel), e.pat);
                check("fill_busy", int'(busy), 1);
                last_addr = e.addr;
                last_data = e.data;
                last_pat  = e.pat;
            end
            frame[addr_out] = data_out;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
                check("missing_write", 0, 1);
                e = exp_q.pop_front();
                last_addr = e.addr;
                last_data = e.data;
                last_pat  = e.pat;
            end
            check("idle_busy", int'(busy), 0);
            check("hold_addr", int'(addr_out), last_addr);
            check("hold_data", int'(data_out), last_data);
            check("idle_sel", int'(pattern_sel), last_pat);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 3000) begin
            step(1);
            t++;
        end
        if (exp_q.size() > 0) check("fill_timeout", exp_q.size(), 0);
        step(3);
    endtask

    task automatic press(input bit r, input bit l);
        int s;
        int np;
        s    = cyc + PRESS_LAT;
        bntr = r;
        bntl = l;
        if (r != l) begin
            np = r ? (model_sel + 1) % 4 : (model_sel + 3) % 4;
            while (exp_q.size() > 0 && exp_q[$].c >= s) void'(exp_q.pop_back());
            push_fill(s, np);
            model_sel = np;
            cur_start = s;
        end
        step(10);
        bntr = 1'b0;
        bntl = 1'b0;
        step(10);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        rst  = 1'b0;
        bntr = 1'b0;
        bntl = 1'b0;
        #1 rst = 1'b1;
        step(3);
        check("rst_regwrite", int'(regwrite), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_addr", int'(addr_out), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_sel", int'(pattern_sel), 0);

        rst = 1'b0;
        push_fill(cyc + 2, 0);
        wait_idle();
        check("solid_px0", int'(frame[0]), 4);
        check("solid_px255", int'(frame[255]), 4);

        press(1'b1, 1'b0);
        wait_idle();
        check("sel_after_right", int'(pattern_sel), 1);
        check("vbar_0x25", int'(frame[8'h25]), 5);
        check("vbar_0x0f", int'(frame[8'h0F]), 7);

        press(1'b0, 1'b1);
        wait_idle();
        press(1'b0, 1'b1);
        wait_idle();
        check("sel_wrap_left", int'(pattern_sel), 3);
        check("check_0x04", int'(frame[8'h04]), 7);
        check("check_0x44", int'(frame[8'h44]), 0);

        for (int i = 0; i < 10; i++) begin
            bntr = (i % 2 == 0);
            step(2);
        end
        press(1'b1, 1'b0);
        wait_idle();
        check("sel_after_bounce", int'(pattern_sel), 0);

        press(1'b1, 1'b0);
        wait_until(cur_start + 101 - PRESS_LAT);
        press(1'b1, 1'b0);
        wait_idle();
        check("sel_after_restart", int'(pattern_sel), 2);
        check("hbar_0x25", int'(frame[8'h25]), 2);

        press(1'b1, 1'b1);
        step(10);
        check("sel_both_pressed", int'(pattern_sel), model_sel);

        for (int i = 0; i < 8; i++) begin
            wait_until(cyc + int'($urandom_range(0, 300)));
            case ($urandom_range(0, 2))
                0:       press(1'b1, 1'b0);
                1:       press(1'b0, 1'b1);
                default: press(1'b1, 1'b1);
            endcase
        end
        wait_idle();
        check("sel_after_random", int'(pattern_sel), model_sel);

        press(1'b1, 1'b0);
        wait_until(cur_start + 50);
        rst = 1'b1;
        #1;
        check("async_rst_regwrite", int'(regwrite), 0);
        check("async_rst_addr", int'(addr_out), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_sel", int'(pattern_sel), 0);
        exp_q.delete();
        last_addr = 0;
        last_data = 0;
        last_pat  = 0;
        model_sel = 0;
        step(3);
        rst = 1'b0;
        push_fill(cyc + 2, 0);
        wait_idle();
        check("refill_px0", int'(frame[0]), 4);
        check("refill_px51", int'(frame[51]), 4);
        check("refill_px255", int'(frame[255]), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
